// File: rtl/text_buffer.sv
// Character-cell text buffer: keyboard-driven cursor editing, scrolling, and a display read port for the font stage.
// Optional feature: define TEXT_BUFFER_CURSOR_BLINK_EN to overlay a blinking '_' on an empty cursor cell.
module text_buffer #(
    parameter int COLS      = 70,
    parameter int ROWS      = 30,
    parameter int BLINK_DIV = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    output logic       key_ready,
    input  logic [9:0] h_addr,
    input  logic [8:0] v_addr,
    output logic [7:0] asc,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);

    typedef enum logic [1:0] {INIT, IDLE, SCROLL} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t     state;
    logic [4:0] top_row;
    logic [4:0] fill_row;
    logic [6:0] fill_col;
    logic [7:0] mem [0:4095];

    // Logical rows are offset by top_row so a scroll never has to move stored text.
    function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
        logic [5:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= 6'(ROWS))
            sum = sum - 6'(ROWS);
        return sum[4:0];
    endfunction

    logic       key_take;
    logic       is_print;
    logic       is_newline;
    logic       is_bs;
    logic       bs_move;
    logic       adv_row;
    logic [6:0] bs_col;
    logic [4:0] bs_row;

    assign key_take   = key_valid && key_ready;
    assign is_print   = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
    assign is_newline = (key_ascii == 8'h0D) || (key_ascii == 8'h0A);
    assign is_bs      = (key_ascii == 8'h08);
    assign bs_move    = is_bs && ((cursor_col != 7'd0) || (cursor_row != 5'd0));
    assign adv_row    = is_newline || (is_print && (cursor_col == LAST_COL));

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        bs_col = cursor_col - 7'd1;
        bs_row = cursor_row;
        if (cursor_col == 7'd0) begin
            bs_col = LAST_COL;
            bs_row = cursor_row - 5'd1;
        end
    end

    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = 8'h00;
        case (state)
            INIT, SCROLL: begin
                wr_en   = 1'b1;
                wr_addr = {fill_row, fill_col};
            end
            IDLE: begin
                if (key_take && is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = {phys_row(cursor_row, top_row), cursor_col};
                    wr_data = key_ascii;
                end else if (key_take && bs_move) begin
                    wr_en   = 1'b1;
                    wr_addr = {phys_row(bs_row, top_row), bs_col};
                end
            end
            default: ;
        endcase
    end

    // NOTE: the cell array has no reset; INIT clears it after every reset release instead.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
            state      <= INIT;
            key_ready  <= 1'b0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            top_row    <= 5'd0;
            fill_row   <= 5'd0;
            fill_col   <= 7'd0;
        end else begin
            case (state)
                INIT: begin
                    if (fill_col == LAST_COL) begin
                        fill_col <= 7'd0;
                        if (fill_row == LAST_ROW) begin
                            fill_row  <= 5'd0;
                            state     <= IDLE;
                            key_ready <= 1'b1;
                        end else begin
                            fill_row <= fill_row + 5'd1;
                        end
                    end else begin
                        fill_col <= fill_col + 7'd1;
                    end
                end
                IDLE: begin
                    if (key_take) begin
                        if (is_print)
                            cursor_col <= (cursor_col == LAST_COL) ? 7'd0 : cursor_col + 7'd1;
                        else if (is_newline)
                            cursor_col <= 7'd0;
                        else if (bs_move) begin
                            cursor_col <= bs_col;
                            cursor_row <= bs_row;
                        end
                        if (adv_row) begin
                            if (cursor_row == LAST_ROW) begin
                                // The old top physical row becomes the new, blank bottom row.
                                top_row   <= (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
                                fill_row  <= top_row;
                                fill_col  <= 7'd0;
                                state     <= SCROLL;
                                key_ready <= 1'b0;
                            end else begin
                                cursor_row <= cursor_row + 5'd1;
                            end
                        end
                    end
                end
                SCROLL: begin
                    if (fill_col == LAST_COL) begin
                        fill_col  <= 7'd0;
                        state     <= IDLE;
                        key_ready <= 1'b1;
                    end else begin
                        fill_col <= fill_col + 7'd1;
                    end
                end
                default: begin
                    state     <= INIT;
                    key_ready <= 1'b0;
                end
            endcase
        end
    end

    logic [6:0]  disp_col;
    logic [4:0]  disp_row;
    logic        disp_in;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        unused_bits;

    assign disp_col    = 7'(h_addr / 10'd9);
    assign disp_row    = v_addr[8:4];
    assign disp_in     = (disp_col < 7'(COLS)) && (disp_row < 5'(ROWS));
    assign rd_addr     = {phys_row(disp_row, top_row), disp_col};
    assign unused_bits = ^v_addr[3:0];

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt;
    logic                 on_cursor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blink_cnt <= '0;
        else
            blink_cnt <= blink_cnt + 1'b1;
    end

    assign on_cursor = (disp_col == cursor_col) && (disp_row == cursor_row);
    assign rd_data   = (on_cursor && blink_cnt[BLINK_DIV-1] && (mem[rd_addr] == 8'h00))
                       ? 8'h5F : mem[rd_addr];
`else
    logic [BLINK_DIV-1:0] unused_blink;

    assign unused_blink = '0;
    assign rd_data      = mem[rd_addr];
`endif

    // Reading the array with a non-blocking register gives old contents on a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            asc <= 8'h00;
        else
            asc <= disp_in ? rd_data : 8'h00;
    end

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: a logical-grid model feeds a scoreboard of expected display reads.
module tb_text_buffer;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic [9:0] h_addr;
    logic [8:0] v_addr;
    logic [7:0] asc;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    text_buffer #(.COLS(COLS), .ROWS(ROWS), .BLINK_DIV(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ascii  (key_ascii),
        .key_ready  (key_ready),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .asc        (asc),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Logical model: grid row 0 is always the top displayed row.
    logic [7:0] grid [ROWS][COLS];
    int cc, cr;

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                grid[r][c] = 8'h00;
        cc = 0;
        cr = 0;
    endtask

    task automatic model_adv();
        if (cr == ROWS - 1) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    grid[r][c] = grid[r+1][c];
            for (int c = 0; c < COLS; c++)
                grid[ROWS-1][c] = 8'h00;
        end else begin
            cr++;
        end
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            grid[cr][cc] = k;
            if (cc == COLS - 1) begin
                cc = 0;
                model_adv();
            end else begin
                cc++;
            end
        end else if (k == 8'h0D || k == 8'h0A) begin
            cc = 0;
            model_adv();
        end else if (k == 8'h08) begin
            if (cc > 0) begin
                cc--;
                grid[cr][cc] = 8'h00;
            end else if (cr > 0) begin
                cr--;
                cc = COLS - 1;
                grid[cr][cc] = 8'h00;
            end
        end
    endtask

    function automatic logic [7:0] exp_at(input int h, input int v);
        int c, r;
        c = h / 9;
        r = v / 16;
        if (c >= COLS || r >= ROWS)
            return 8'h00;
        return grid[r][c];
    endfunction

    typedef struct {
        int         h;
        int         v;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb [$];

    task automatic sb_pop_check();
        sb_entry_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("asc@h%0d,v%0d", e.h, e.v), {24'd0, asc}, {24'd0, e.exp});
        end
    endtask

    // One display read per cycle: compare the previous address, then present the next.
    task automatic disp_step(input int h, input int v);
        sb_entry_t e;
        @(negedge clk);
        sb_pop_check();
        h_addr = 10'(h);
        v_addr = 9'(v);
        e.h = h;
        e.v = v;
        e.exp = exp_at(h, v);
        sb.push_back(e);
    endtask

    task automatic disp_drain();
        @(negedge clk);
        sb_pop_check();
    endtask

    task automatic scan_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                disp_step(c * 9 + (c % 9), r * 16 + (r % 16));
        disp_step(639, 0);
        disp_step(639, 479);
        disp_step(0, 500);
        disp_drain();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, {25'd0, cursor_col}, cc);
        check({tag, "_row"}, {27'd0, cursor_row}, cr);
    endtask

    task automatic send_key(input logic [7:0] k);
        @(negedge clk);
        check("key_ready_before_key", {31'd0, key_ready}, 1);
        key_ascii = k;
        key_valid = 1'b1;
        model_key(k);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic release_and_init();
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (key_ready)
                break;
        end
        check("init_cycles", n, ROWS * COLS);
    endtask

    initial begin
        int n;
        sb_entry_t e;

        rst = 1'b1;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        h_addr = 10'd4;
        v_addr = 9'd3;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_asc", {24'd0, asc}, 0);
        check("rst_key_ready", {31'd0, key_ready}, 0);
        check("rst_cursor_col", {25'd0, cursor_col}, 0);
        check("rst_cursor_row", {27'd0, cursor_row}, 0);

        release_and_init();
        scan_screen();

        // Backspace at the origin and non-printable codes change nothing.
        send_key(8'h08);
        send_key(8'h07);
        send_key(8'h7F);
        send_key(8'h00);
        check_cursor("origin_noop");

        send_key(8'h48);
        send_key(8'h69);
        disp_step(4, 3);
        disp_step(9, 0);
        disp_drain();
        check_cursor("after_hi");

        // Display read of the cursor cell on the same cycle the key writes it.
        @(negedge clk);
        h_addr = 10'(cc * 9);
        v_addr = 9'(cr * 16);
        e.h = cc * 9;
        e.v = cr * 16;
        e.exp = exp_at(e.h, e.v);
        sb.push_back(e);
        check("key_ready_collision", {31'd0, key_ready}, 1);
        key_ascii = 8'h5A;
        key_valid = 1'b1;
        model_key(8'h5A);
        @(negedge clk);
        key_valid = 1'b0;
        sb_pop_check();
        disp_step(18, 0);
        disp_drain();

        send_key(8'h0D);
        check_cursor("after_cr");
        for (int i = 0; i < COLS; i++)
            send_key(8'(8'h21 + i));
        check_cursor("row_wrap");
        send_key(8'h08);
        check_cursor("bs_wrap");
        disp_step(69 * 9, 16);
        disp_step(68 * 9, 16);
        disp_drain();

        for (int i = 0; i < 28; i++)
            send_key(8'h0D);
        check_cursor("at_bottom");
        send_key(8'h41);
        send_key(8'h42);

        // Newline on the bottom row starts a scroll; a key offered mid-scroll must be dropped.
        @(negedge clk);
        key_ascii = 8'h0D;
        key_valid = 1'b1;
        model_key(8'h0D);
        n = 0;
        while (n < 500) begin
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            if (key_ready)
                break;
            n++;
            if (n == 20) begin
                key_ascii = 8'h58;
                key_valid = 1'b1;
            end
        end
        check("scroll_busy_cycles", n, COLS);
        check_cursor("after_scroll");
        scan_screen();

        // Reset in the middle of a second scroll.
        @(negedge clk);
        key_ascii = 8'h0D;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midscroll_rst_asc", {24'd0, asc}, 0);
        check("midscroll_rst_key_ready", {31'd0, key_ready}, 0);
        check("midscroll_rst_cursor_col", {25'd0, cursor_col}, 0);
        check("midscroll_rst_cursor_row", {27'd0, cursor_row}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        release_and_init();
        scan_screen();
        send_key(8'h31);
        disp_step(0, 0);
        disp_drain();
        check_cursor("post_reset_key");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter COLS, default 70, meaning character columns per row (9-pixel cells).
REQ-002 SHALL have parameter ROWS, default 30, meaning character rows (16-pixel cells).
REQ-003 SHALL have parameter BLINK_DIV, default 24, meaning cursor blink counter width in bits.
REQ-004 SHALL have port clk  input  1  system/pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port key_valid  input  1  one-cycle strobe: key_ascii holds a code.
REQ-007 SHALL have port key_ascii  input  8  ASCII code of the key.
REQ-008 SHALL have port key_ready  output  1  high when a key can be accepted.
REQ-009 SHALL have port h_addr  input  10  current pixel column, 0..639.
REQ-010 SHALL have port v_addr  input  9  current pixel row, 0..479.
REQ-011 SHALL have port asc  output  8  character code of the cell containing (h_addr, v_addr), fed to the font stage.
REQ-012 SHALL have port cursor_col  output  7  logical cursor column.
REQ-013 SHALL have port cursor_row  output  5  logical cursor row, 0 = top displayed row.

Function
REQ-014 SHALL store one 8-bit code per cell in a 4096-entry memory addressed {phys_row[4:0], col[6:0]}; code 0x00 means blank.
REQ-015 SHALL implement states INIT, IDLE, SCROLL; key_ready = 1 only in IDLE.
REQ-016 INIT SHALL write 0x00 to all ROWS*COLS cells, one per cycle, then enter IDLE.
REQ-017 A key SHALL be accepted only on a cycle with key_valid=1 and key_ready=1; other key_valid pulses SHALL be dropped.
REQ-018 Printable code 0x20..0x7E SHALL be written at the cursor and the cursor advanced one column; at column COLS-1 the advance SHALL set col=0 and row+1.
REQ-019 Code 0x0D or 0x0A SHALL set col=0 and row+1 without writing.
REQ-020 Code 0x08 SHALL move the cursor back one cell and write 0x00 there: from col>0 to col-1; from col=0,row>0 to (COLS-1,row-1); at (0,0) no effect.
REQ-021 All other codes SHALL be ignored.
REQ-022 A row advance from row ROWS-1 SHALL leave row at ROWS-1, increment top_row modulo ROWS, and enter SCROLL.
REQ-023 SCROLL SHALL write 0x00 to the COLS cells of the new bottom physical row, one per cycle, then return to IDLE.
REQ-024 Physical row SHALL be (logical row + top_row) mod ROWS for both writes and display reads.
REQ-025 Display column SHALL be h_addr/9; display row SHALL be v_addr>>4.
REQ-026 asc SHALL be registered with exactly one clk of latency from h_addr/v_addr.
REQ-027 asc SHALL be 0x00 when the column is >= COLS or the row is >= ROWS.
REQ-028 A display read and a key write to the same cell in the same cycle SHALL return the old contents.

Reset
REQ-029 While rst=1, outputs SHALL be: asc=0x00, cursor_col=0, cursor_row=0, key_ready=0; top_row SHALL be 0 and the blink counter 0.
REQ-030 Release of rst SHALL enter INIT; assertion from any state, including mid-SCROLL, SHALL abort the operation.

Configuration
REQ-031 With macro TEXT_BUFFER_CURSOR_BLINK_EN defined, the cell under the cursor SHALL read as 0x5F while the blink counter MSB is 1 and the cell holds 0x00.
REQ-032 Without TEXT_BUFFER_CURSOR_BLINK_EN, there SHALL be no blink counter or cursor overlay, and asc SHALL be the raw memory contents.

Verification
REQ-033 Reset, release -> key_ready=0 for 2100 cycles, then 1; every cell reads 0x00.
REQ-034 Keys 'H'(0x48), 'i'(0x69) -> cells (0,0)=0x48 and (1,0)=0x69; asc=0x48 one cycle after h_addr=4, v_addr=3; cursor=(2,0).
REQ-035 70 printable keys from (0,0) -> cursor=(0,1); then 0x08 -> cursor=(69,0), cell cleared to 0x00.
REQ-036 Cursor at row 29, key 0x0D -> key_ready=0 for 70 cycles; top_row=1; row-1 contents now displayed at row 0; row 29 blank.
REQ-037 key_valid pulse during SCROLL -> key dropped, buffer and cursor unchanged.
REQ-038 rst asserted mid-SCROLL -> outputs at reset values immediately; full INIT follows release.
